// File: rtl/adda_pkg.sv
// rtl/adda_pkg.sv - shared sample width default and signed sample type
package adda_pkg;

  localparam int ADDA_DATA_WIDTH = 14;

  typedef logic signed [ADDA_DATA_WIDTH-1:0] sample_t;

endpackage : adda_pkg

// File: rtl/adc_sample_fifo_if.sv
// rtl/adc_sample_fifo_if.sv - write/read/status bundle of the sample FIFO
interface adc_sample_fifo_if
  import adda_pkg::*;
#(
  parameter int DATA_WIDTH = ADDA_DATA_WIDTH,
  parameter int ADDR_WIDTH = 4
);

  logic                         wr_en;
  logic signed [DATA_WIDTH-1:0] din;
  logic                         rd_en;
  logic signed [DATA_WIDTH-1:0] dout;
  logic                         full;
  logic                         empty;
  logic                         above_half;
  logic [ADDR_WIDTH:0]          count;
  logic                         overflow;
  logic                         underflow;

  // Producer/consumer side: drives the requests, observes head word and status
  modport master (
    output wr_en, din, rd_en,
    input  dout, full, empty, above_half, count, overflow, underflow
  );

  // FIFO side
  modport slave (
    input  wr_en, din, rd_en,
    output dout, full, empty, above_half, count, overflow, underflow
  );

endinterface : adc_sample_fifo_if

// File: rtl/adc_sample_fifo.sv
// rtl/adc_sample_fifo.sv - first-word-fall-through signed sample FIFO with half-level flag
module adc_sample_fifo
  import adda_pkg::*;
#(
  parameter int DATA_WIDTH = ADDA_DATA_WIDTH,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  adc_sample_fifo_if.slave    bus
);

  localparam int                  DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] HALF_CNT  = (ADDR_WIDTH + 1)'(DEPTH / 2);

  logic signed [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0]        wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]        rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]          count_q, count_d;
  logic                         overflow_q, overflow_d;
  logic                         underflow_q, underflow_d;

  logic full_w;
  logic empty_w;
  logic rd_ok;
  logic wr_ok;

  // Status decoded from the registered count only, so flags never glitch
  assign full_w  = (count_q == DEPTH_CNT);
  assign empty_w = (count_q == '0);

  // A read needs a stored word; a write into a full FIFO is fine when a read frees a slot
  // in the same cycle. A write into an empty FIFO never satisfies a same-cycle read.
  assign rd_ok = bus.rd_en && !empty_w;
  assign wr_ok = bus.wr_en && (!full_w || rd_ok);

  // Next-state for pointers, fill level and sticky error flags
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q  | (bus.wr_en && !wr_ok);
    underflow_d = underflow_q | (bus.rd_en && empty_w);
    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (wr_ok && !rd_ok) begin
      count_d = count_q + 1'b1;
    end else if (rd_ok && !wr_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  // Sample storage; cleared on reset so the head word reads 0 rather than X
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_ok) begin
      mem_q[wr_ptr_q] <= bus.din;
    end
  end

  // Pointer, level and error-flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.dout       = mem_q[rd_ptr_q];
  assign bus.full       = full_w;
  assign bus.empty      = empty_w;
  assign bus.above_half = (count_q >= HALF_CNT);
  assign bus.count      = count_q;
  assign bus.overflow   = overflow_q;
  assign bus.underflow  = underflow_q;

endmodule : adc_sample_fifo

// File: tb/tb_adc_sample_fifo.sv
// tb/tb_adc_sample_fifo.sv - scoreboard bench for adc_sample_fifo
module tb_adc_sample_fifo;
  import adda_pkg::*;

  localparam int DW    = 14;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk;
  logic rst_n;

  adc_sample_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  adc_sample_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  sample_t exp_q[$];
  int      m_count;
  bit      m_ovf;
  bit      m_udf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, ".count"}, 32'(bus.count), 32'(m_count));
    check({tag, ".empty"}, 32'(bus.empty), 32'(m_count == 0));
    check({tag, ".full"},  32'(bus.full),  32'(m_count == DEPTH));
    check({tag, ".ahalf"}, 32'(bus.above_half), 32'(m_count >= DEPTH / 2));
    check({tag, ".ovf"},   32'(bus.overflow),  32'(m_ovf));
    check({tag, ".udf"},   32'(bus.underflow), 32'(m_udf));
  endtask

  // One clock of traffic: drive, verify head word for an accepted read, clock, update model, verify status
  task automatic step(input string tag, input bit we, input sample_t d, input bit re);
    bit rd_ok;
    bit wr_ok;
    sample_t e;
    rd_ok = re && (m_count > 0);
    wr_ok = we && ((m_count < DEPTH) || rd_ok);
    bus.wr_en = we;
    bus.din   = d;
    bus.rd_en = re;
    #1;
    if (rd_ok) begin
      e = exp_q.pop_front();
      check({tag, ".dout"}, 32'(bus.dout), 32'(e));
    end
    if (wr_ok) exp_q.push_back(d);
    if (we && !wr_ok) m_ovf = 1'b1;
    if (re && m_count == 0) m_udf = 1'b1;
    if (wr_ok && !rd_ok) m_count++;
    else if (rd_ok && !wr_ok) m_count--;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    check_status(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.din   = '0;
    exp_q.delete();
    m_count = 0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    do_reset();

    check_status("reset");
    check("reset.dout", 32'(bus.dout), 32'd0);

    for (int i = 1; i <= DEPTH; i++) step("fill", 1'b1, sample_t'(i), 1'b0);
    step("fill17", 1'b1, sample_t'(17), 1'b0);
    check("fill17.dout", 32'(bus.dout), 32'd1);

    for (int i = 1; i <= DEPTH; i++) step("drain", 1'b0, '0, 1'b1);
    step("drain_extra", 1'b0, '0, 1'b1);

    do_reset();
    for (int i = 1; i <= DEPTH; i++) step("fill2", 1'b1, sample_t'(i), 1'b0);
    step("simul_full", 1'b1, sample_t'(100), 1'b1);
    for (int i = 0; i < DEPTH; i++) step("drain2", 1'b0, '0, 1'b1);

    step("empty_wr_rd", 1'b1, sample_t'(-5), 1'b1);
    step("pop_neg", 1'b0, '0, 1'b1);

    for (int i = 0; i < 8; i++) step("prime", 1'b1, sample_t'(200 + i), 1'b0);
    for (int i = 0; i < 40; i++) step("stream", 1'b1, sample_t'(-300 - i), 1'b1);
    for (int i = 0; i < 8; i++) step("flush", 1'b0, '0, 1'b1);

    do_reset();
    for (int i = 0; i < 5; i++) step("pre_rst", 1'b1, sample_t'(50 + i), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    m_count = 0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    check_status("async_rst");
    check("async_rst.dout", 32'(bus.dout), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("post_rst_w0", 1'b1, sample_t'(7), 1'b0);
    step("post_rst_w1", 1'b1, sample_t'(8), 1'b0);
    check("post_rst.head", 32'(bus.dout), 32'(sample_t'(7)));
    step("post_rst_r0", 1'b0, '0, 1'b1);
    step("post_rst_r1", 1'b0, '0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_adc_sample_fifo
